// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - div_state_e   : controller states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand width
//   - count_width() : width of the iteration counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The counter has to hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor, a - b, built as a ripple
// chain of full adders with b inverted and carry-in tied to 1 (same structure
// as the add_sub datapath).
// Ports:
//   a      : minuend, WIDTH+1 bits
//   b      : subtrahend, WIDTH+1 bits
//   diff   : low WIDTH bits of the difference
//   borrow : MSB of the (WIDTH+1)-bit difference; 1 means a < b
module trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] b_inv_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] carry_s;    // carry into each bit position

    assign b_inv_s    = ~b;
    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum_s[i] = a[i] ^ b_inv_s[i] ^ carry_s[i];
        if (i < WIDTH) begin : g_carry
            assign carry_s[i+1] = (a[i] & b_inv_s[i]) | (carry_s[i] & (a[i] ^ b_inv_s[i]));
        end
    end

    // The operands never differ by more than 2^WIDTH in magnitude, so the
    // top bit of the difference is a reliable sign/borrow indicator.
    assign diff   = sum_s[WIDTH-1:0];
    assign borrow = sum_s[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, accepted when not busy (IDLE or DONE)
//   dividend     : numerator, captured with start
//   divisor      : denominator, captured with start
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid from this cycle on
//   quotient     : result quotient (working register while busy)
//   remainder    : result remainder (partial remainder while busy)
//   div_by_zero  : set with done when the divisor was zero
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = count_width(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

    div_state_e        state_r, state_next_s;
    logic [WIDTH-1:0]  qreg_r, qreg_next_s;
    logic [WIDTH-1:0]  rem_r, rem_next_s;
    logic [WIDTH-1:0]  divisor_r, divisor_next_s;
    logic [CW-1:0]     count_r, count_next_s;
    logic              dbz_r, dbz_next_s;
    logic              busy_r, done_r;
    logic              accept_s;

    logic [WIDTH:0]    shifted_s;
    logic [WIDTH-1:0]  trial_diff_s;
    logic              trial_borrow_s;

    assign shifted_s = {rem_r, qreg_r[WIDTH-1]};

    trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .a      (shifted_s),
        .b      ({1'b0, divisor_r}),
        .diff   (trial_diff_s),
        .borrow (trial_borrow_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_next_s   = state_r;
        qreg_next_s    = qreg_r;
        rem_next_s     = rem_r;
        divisor_next_s = divisor_r;
        count_next_s   = count_r;
        dbz_next_s     = dbz_r;
        accept_s       = 1'b0;

        case (state_r)
            IDLE: begin
                accept_s = start;
            end
            RUN: begin
                if (trial_borrow_s) begin
                    rem_next_s = shifted_s[WIDTH-1:0];
                end else begin
                    rem_next_s = trial_diff_s;
                end
                qreg_next_s  = {qreg_r[WIDTH-2:0], ~trial_borrow_s};
                count_next_s = count_r - CNT_ONE;
                if (count_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                // A start arriving together with the done pulse is accepted
                // immediately so back-to-back operations lose no cycle.
                accept_s     = start;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        // Operand capture overrides the per-state defaults above.
        if (accept_s) begin
            if (divisor == {WIDTH{1'b0}}) begin
                qreg_next_s  = {WIDTH{1'b1}};
                rem_next_s   = dividend;
                dbz_next_s   = 1'b1;
                count_next_s = {CW{1'b0}};
                state_next_s = DONE;
            end else begin
                qreg_next_s    = dividend;
                rem_next_s     = {WIDTH{1'b0}};
                divisor_next_s = divisor;
                dbz_next_s     = 1'b0;
                count_next_s   = CNT_INIT;
                state_next_s   = RUN;
            end
        end else begin
            divisor_next_s = divisor_next_s;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            qreg_r    <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            dbz_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            qreg_r    <= qreg_next_s;
            rem_r     <= rem_next_s;
            divisor_r <= divisor_next_s;
            count_r   <= count_next_s;
            dbz_r     <= dbz_next_s;
            busy_r    <= (state_next_s == RUN);
            done_r    <= (state_next_s == DONE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = qreg_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule
